counter_sweep_ctrl: RTL

// - Sequencer for the 8-bit enable/inc_dec up/down counter. Drives the counter's enable and
//   inc_dec pins to run N triangle sweeps 0 -> LIMIT -> 0, then parks it.
// - Tracks a shadow count and flags any divergence from the counter's actual output.
// - Sits between the control logic (start/abort, config) and one counter instance.

---
 rtl/counter_ctrl_pkg.sv | 8 +
 rtl/counter_sweep_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: state encoding and config limits shared by the counter sweep sequencer
package counter_ctrl_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    localparam int MIN_LIMIT = 2;
endpackage

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: runs N triangle sweeps 0->limit->0 on an enable/inc_dec counter and checks it against a shadow count
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SWEEP_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   limit,
    input  logic [SWEEP_W-1:0] n_sweeps,
    input  logic [WIDTH-1:0]   cnt_value,
    output logic               cnt_enable,
    output logic               cnt_inc_dec,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [SWEEP_W-1:0] sweep_idx,
    output logic               mismatch
);
    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d, limit_q, limit_d;
    logic [SWEEP_W-1:0] n_sweeps_q, n_sweeps_d, sweep_idx_q, sweep_idx_d;
    logic               mismatch_q, mismatch_d, cfg_err_q, cfg_err_d;
    logic               cfg_ok, last_sweep;

    assign cfg_ok = (limit >= WIDTH'(MIN_LIMIT)) && (n_sweeps != '0);
    assign last_sweep = sweep_idx_q == n_sweeps_q - SWEEP_W'(1);

    always_comb begin
        state_d = state_q;
        shadow_d = shadow_q;
        limit_d = limit_q;
        n_sweeps_d = n_sweeps_q;
        sweep_idx_d = sweep_idx_q;
        cfg_err_d = 1'b0;
        mismatch_d = mismatch_q | ((state_q != ST_IDLE) && (cnt_value != shadow_q));
        if (state_q == ST_IDLE) begin
            // abort outranks start even while idle
            if (start && !abort) begin
                if (cfg_ok) begin
                    state_d = ST_UP;
                    limit_d = limit;
                    n_sweeps_d = n_sweeps;
                    sweep_idx_d = '0;
                    shadow_d = '0;
                    mismatch_d = 1'b0;
                end else begin
                    cfg_err_d = 1'b1;
                end
            end
        end else if (abort || state_q == ST_DONE) begin
            state_d = ST_IDLE;
            shadow_d = '0;
        end else if (state_q == ST_UP) begin
            shadow_d = shadow_q + WIDTH'(1);
            // turn one cycle early so the counter peaks exactly at limit
            state_d = (shadow_q == limit_q - WIDTH'(1)) ? ST_DOWN : ST_UP;
        end else begin
            shadow_d = shadow_q - WIDTH'(1);
            if (shadow_q == WIDTH'(1)) begin
                state_d = last_sweep ? ST_DONE : ST_UP;
                sweep_idx_d = last_sweep ? sweep_idx_q : sweep_idx_q + SWEEP_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shadow_q <= '0;
            limit_q <= '0;
            n_sweeps_q <= '0;
            sweep_idx_q <= '0;
            mismatch_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shadow_q <= shadow_d;
            limit_q <= limit_d;
            n_sweeps_q <= n_sweeps_d;
            sweep_idx_q <= sweep_idx_d;
            mismatch_q <= mismatch_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cnt_enable = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign cnt_inc_dec = state_q == ST_UP;
    assign busy = cnt_enable;
    assign done = state_q == ST_DONE;
    assign cfg_err = cfg_err_q;
    assign sweep_idx = sweep_idx_q;
    assign mismatch = mismatch_q;
endmodule
